// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake,
// optional two's-complement mode via magnitude divide plus sign fixup.
module seq_divider #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             neg_q;
  logic             neg_r;
  logic             zdiv;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and the one-bit-wider trial subtract of the current step.
  always_comb begin
    sign_a  = SIGNED && opa[WIDTH-1];
    sign_b  = SIGNED && opb[WIDTH-1];
    mag_a   = sign_a ? WIDTH'(-opa) : opa;
    mag_b   = sign_b ? WIDTH'(-opb) : opb;
    shifted = {prem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zdiv        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            dvs         <= mag_b;
            prem        <= '0;
            cnt         <= '0;
            if (opb == '0) begin
              // Raw dividend kept so the zero-divisor remainder is opa unchanged.
              zdiv  <= 1'b1;
              dvd   <= opa;
              state <= FIN;
            end else begin
              zdiv  <= 1'b0;
              dvd   <= mag_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (zdiv) begin
            quot        <= '1;
            rem         <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            quot <= neg_q ? WIDTH'(-dvd) : dvd;
            rem  <= neg_r ? WIDTH'(-prem) : prem;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: unsigned and signed instances checked against an arithmetic model.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_u = 1'b0;
  logic         start_s = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;

  logic         busy_u, done_u, dbz_u, busy_s, done_s, dbz_s;
  logic [W-1:0] quot_u, rem_u, quot_s, rem_s;

  bit           sel = 1'b0;
  logic         o_busy, o_done, o_dbz;
  logic [W-1:0] o_quot, o_rem;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_div_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .opa(opa), .opb(opb),
    .busy(busy_u), .done(done_u), .quot(quot_u), .rem(rem_u), .div_by_zero(dbz_u)
  );

  seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_div_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .opa(opa), .opb(opb),
    .busy(busy_s), .done(done_s), .quot(quot_s), .rem(rem_s), .div_by_zero(dbz_s)
  );

  assign o_busy = sel ? busy_s : busy_u;
  assign o_done = sel ? done_s : done_u;
  assign o_dbz  = sel ? dbz_s  : dbz_u;
  assign o_quot = sel ? quot_s : quot_u;
  assign o_rem  = sel ? rem_s  : rem_u;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; 64-bit signed math covers the min/-1 case.
  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sa;
    longint sb;
    z = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    sel = s;
    opa = a;
    opb = b;
    if (s) start_s = 1'b1;
    else   start_u = 1'b1;
  endtask

  // Called at the negedge where start was raised; returns at the negedge where done is seen.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit inject, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, bcnt;
    bit           got;
    ref_div(sel, a, b, eq, er, ez);
    lat  = 0;
    bcnt = 0;
    got  = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      start_u = 1'b0;
      start_s = 1'b0;
      opa = $urandom;
      opb = $urandom;
      if (inject && (lat == 5 || lat == 20)) begin
        if (sel) start_s = 1'b1;
        else     start_u = 1'b1;
      end
      if (o_done) got = 1'b1;
      else if (o_busy) bcnt++;
    end
    check({tag, " done_seen"}, W'(got), W'(1));
    check({tag, " latency"}, W'(lat - 1), ez ? W'(1) : W'(W + 1));
    check({tag, " busy_cycles"}, W'(bcnt), ez ? W'(1) : W'(W + 1));
    check({tag, " busy_at_done"}, W'(o_busy), W'(0));
    check({tag, " quot"}, o_quot, eq);
    check({tag, " rem"}, o_rem, er);
    check({tag, " dbz"}, W'(o_dbz), W'(ez));
  endtask

  task automatic check_idle_hold(input string tag, input logic [W-1:0] q, input logic [W-1:0] r);
    @(negedge clk);
    start_u = 1'b0;
    start_s = 1'b0;
    check({tag, " done_pulse"}, W'(o_done), W'(0));
    check({tag, " quot_hold"}, o_quot, q);
    check({tag, " rem_hold"}, o_rem, r);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W-1:0] q, r;
    logic         z;
    bit           s;

    repeat (3) @(negedge clk);
    check("rst busy_u", W'(busy_u), W'(0));
    check("rst done_u", W'(done_u), W'(0));
    check("rst quot_u", quot_u, '0);
    check("rst rem_u", rem_u, '0);
    check("rst dbz_u", W'(dbz_u), W'(0));
    check("rst busy_s", W'(busy_s), W'(0));
    check("rst quot_s", quot_s, '0);
    check("rst rem_s", rem_s, '0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(1'b0, 32'd100, 32'd7);
    wait_done(32'd100, 32'd7, 1'b0, "u100_7");
    check_idle_hold("u100_7", 32'd14, 32'd2);

    launch(1'b0, 32'h1234, 32'h0);
    wait_done(32'h1234, 32'h0, 1'b0, "u_dbz");
    check_idle_hold("u_dbz", 32'hFFFF_FFFF, 32'h1234);
    check("u_dbz held", W'(dbz_u), W'(1));

    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(32'hFFFF_FFF9, 32'd2, 1'b0, "s_m7_2");
    check("s_m7_2 quot_lit", quot_s, 32'hFFFF_FFFD);
    check("s_m7_2 rem_lit", rem_s, 32'hFFFF_FFFF);
    check_idle_hold("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_ovf");
    check("s_ovf quot_lit", quot_s, 32'h8000_0000);
    check("s_ovf rem_lit", rem_s, 32'h0);
    check_idle_hold("s_ovf", 32'h8000_0000, 32'h0);

    // Starts pulsed mid-operation must be dropped.
    launch(1'b0, 32'd1000, 32'd9);
    wait_done(32'd1000, 32'd9, 1'b1, "u_ignore");
    check_idle_hold("u_ignore", 32'd111, 32'd1);

    // Start held in the done cycle chains the next operation.
    launch(1'b0, 32'd5000, 32'd13);
    wait_done(32'd5000, 32'd13, 1'b0, "b2b_a");
    launch(1'b0, 32'd77, 32'd0);
    wait_done(32'd77, 32'd0, 1'b0, "b2b_b");
    launch(1'b0, 32'd4096, 32'd3);
    wait_done(32'd4096, 32'd3, 1'b0, "b2b_c");
    check_idle_hold("b2b_c", 32'd1365, 32'd1);

    // Reset mid-CALC: outputs clear asynchronously, nothing pending afterwards.
    launch(1'b0, 32'd999, 32'd10);
    repeat (10) begin
      @(negedge clk);
      start_u = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rstmid busy", W'(busy_u), W'(0));
    check("rstmid done", W'(done_u), W'(0));
    check("rstmid quot", quot_u, '0);
    check("rstmid rem", rem_u, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_u || busy_u) check("rstmid stray", {30'd0, busy_u, done_u}, '0);
    end
    check("rstmid quiet quot", quot_u, '0);
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(32'hFFFF_FFFF, 32'd1, 1'b0, "post_rst");

    for (int k = 0; k < 1000; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'd1;
        2: b = a;
        3: begin a = $urandom_range(0, 1000); b = $urandom_range(1001, 32'hFFFF_FFFF); end
        4: b = '1;
        5: b = $urandom_range(1, 15);
        6: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? '1 : $urandom; end
        default: b = $urandom;
      endcase
      ref_div(s, a, b, q, r, z);
      launch(s, a, b);
      wait_done(a, b, ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) != 0) check_idle_hold("rand", q, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
